data_sel_reg: RTL and testbench
===============================

Name: data_sel_reg

Overview:
Parametrised, registered successor to the two-way data-register input mux. It selects one of NUM_CH word sources and captures the selected word into a single-entry output register, with valid/ready handshakes on every input and on the output. Arbitration is fixed-priority or round-robin. It sits in front of the 128-bit state/data register and feeds the processing datapath, replacing the hard-wired select line.

Parameters:
DATA_WIDTH, 128, width of each data word
NUM_CH, 2, number of input channels (2..8)
RR_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
CNT_W, 16, width of the accepted-word counter

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of the held word and arbitration state
in_valid  input  NUM_CH  per-channel word available
in_data  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_ready  output  NUM_CH  one-hot (or zero) grant; a word transfers on channel i when in_valid[i] and in_ready[i]
out_valid  output  1  output register holds a word
out_data  output  DATA_WIDTH  held word
out_src  output  clog2(NUM_CH)  channel index of the held word
out_ready  input  1  downstream accepts out_data
acc_count  output  CNT_W  total words accepted since reset/clear; wraps modulo 2^CNT_W

Behaviour:
- Reset (n_rst=0, asynchronous): out_valid=0, out_data=0, out_src=0, acc_count=0, RR pointer=0. in_ready is combinational and therefore 0 while out_valid=0 and no in_valid is set.
- Register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- can_accept = !out_valid || out_ready. The held word may be replaced in the same cycle it drains, so throughput is 1 word/clk.
- Arbitration (combinational):
  - Considers only channels with in_valid=1.
  - RR_MODE=0: the lowest index wins.
  - RR_MODE=1: search starts at ptr and ascends modulo NUM_CH; the first valid channel wins.
  - in_ready[g]=can_accept for the winner g; all other bits are 0. At most one bit is ever set.
  - in_ready does not depend on in_valid of non-winning channels beyond arbitration.
- On a transfer (rising edge with in_valid[g] && in_ready[g]):
  - out_data <= word g; out_src <= g; out_valid <= 1.
  - acc_count <= acc_count+1, wrapping.
  - RR only: ptr <= (g+1) mod NUM_CH.
- Latency: input transfer to out_valid/out_data is 1 clk.
- Drain without reload (out_valid && out_ready, no input transfer): out_valid <= 0. out_data and out_src hold their last value.
- FULL with out_ready=0: all in_ready=0; out_data and out_src are stable; out_valid stays 1 (no drop, no overwrite).
- Pointer rules: ptr advances only on a transfer, never on idle cycles. In RR mode, wrap from NUM_CH-1 goes to 0.
- clear=1, synchronous, overrides everything that cycle:
  - in_ready forced to all 0, so no transfer occurs.
  - Next edge: out_valid=0, out_src=0, out_data=0, ptr=0, acc_count=0.
  - An out_ready handshake in the same cycle is discarded.
- Reset asserted mid-transfer: outputs go to reset values immediately; the in-flight word is lost.
- Input contract: in_data and in_valid must be held stable by a source until accepted. The block does not check this.

Test Plan:
- Reset then idle: hold n_rst=0 3 clk, release, all in_valid=0 -> out_valid=0, out_data=0, acc_count=0, in_ready=2'b00.
- Single-channel pass (NUM_CH=2, RR_MODE=0): out_ready=1, in_valid=2'b01, ch0 word=128'hA5..A5 for 1 clk -> next clk out_valid=1, out_data=A5..A5, out_src=0, acc_count=1; following clk out_valid=0.
- Fixed priority contention: both valid, ch0=0x11.., ch1=0x22.., out_ready=1, 2 clk -> cycle 1 captures ch0; ch1 is only granted after ch0 deasserts in_valid; acc_count counts each transfer.
- Round-robin (NUM_CH=4, RR_MODE=1): all 4 valid continuously, out_ready=1, 8 clk -> out_src sequence 0,1,2,3,0,1,2,3; in_ready one-hot each cycle.
- Backpressure: FULL with out_ready=0 for 5 clk while ch1 valid -> in_ready=0, out_data unchanged; raise out_ready -> ch1 captured on that same edge, out_valid stays 1 with no bubble.
- Clear and counter wrap (CNT_W=4): 16 transfers -> acc_count=0 after wrap; clear asserted while FULL -> next clk out_valid=0, ptr=0, acc_count=0, no in_ready during the clear cycle.

Source files
------------

// File: rtl/data_sel_reg.sv
// ============================================================================
//  Module   : data_sel_reg
//  Purpose  : N-way valid/ready word selector with a single-entry output
//             register; fixed-priority or round-robin arbitration.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module data_sel_reg #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_CH     = 2,
  parameter int RR_MODE    = 0,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         clear,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_src,
  input  logic                         out_ready,
  output logic [CNT_W-1:0]             acc_count
);

  localparam int SRC_W = $clog2(NUM_CH);
  localparam logic [SRC_W:0] C_NUM_CH = (SRC_W+1)'(NUM_CH);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]            r_state;
  logic [0:0]            w_state_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SRC_W-1:0]      r_src;
  logic [CNT_W-1:0]      r_count;

  logic [SRC_W-1:0]      w_base;
  logic [2*NUM_CH-1:0]   w_valid_x2;
  logic [NUM_CH-1:0]     w_valid_rot;
  logic [SRC_W-1:0]      w_offset;
  logic [SRC_W:0]        w_sum;
  logic [SRC_W-1:0]      w_grant;
  logic [DATA_WIDTH-1:0] w_word;
  logic                  w_any;
  logic                  w_can_accept;
  logic                  w_xfer;

  // Rotate the request vector so that bit 0 is the channel at the search base.
  assign w_valid_x2  = {in_valid, in_valid};
  assign w_valid_rot = NUM_CH'(w_valid_x2 >> w_base);

  always_comb begin
    w_any    = 1'b0;
    w_offset = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_valid_rot[k]) begin
        w_any    = 1'b1;
        w_offset = SRC_W'(k);
      end
    end
  end

  assign w_sum   = {1'b0, w_base} + {1'b0, w_offset};
  assign w_grant = (w_sum >= C_NUM_CH) ? SRC_W'(w_sum - C_NUM_CH) : w_sum[SRC_W-1:0];

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_grant == SRC_W'(k)) begin
        w_word = in_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The held word may be replaced on the same edge it drains.
  assign w_can_accept = (r_state == ST_EMPTY) || out_ready;
  assign w_xfer       = w_any && w_can_accept && !clear;
  assign in_ready     = w_xfer ? (NUM_CH'(1) << w_grant) : '0;

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [SRC_W-1:0] r_ptr;
      logic [SRC_W:0]   w_inc;
      logic [SRC_W-1:0] w_ptr_nxt;

      assign w_inc     = {1'b0, w_grant} + (SRC_W+1)'(1);
      assign w_ptr_nxt = (w_inc == C_NUM_CH) ? '0 : w_inc[SRC_W-1:0];
      assign w_base    = r_ptr;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          r_ptr <= '0;
        end else if (clear) begin
          r_ptr <= '0;
        end else if (w_xfer) begin
          r_ptr <= w_ptr_nxt;
        end
      end
    end else begin : g_fixed
      assign w_base = '0;
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_EMPTY;
    end else if (w_xfer) begin
      w_state_nxt = ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data  <= '0;
      r_src   <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_data  <= '0;
      r_src   <= '0;
      r_count <= '0;
    end else if (w_xfer) begin
      r_data  <= w_word;
      r_src   <= w_grant;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_valid = (r_state == ST_FULL);
  assign out_data  = r_data;
  assign out_src   = r_src;
  assign acc_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_data_sel_reg.sv
// Bench for data_sel_reg: three configurations (2ch fixed, 4ch RR, 3ch RR)
// checked every cycle against a behavioural model plus directed literal checks.
`default_nettype none

module tb_data_sel_reg;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   drv_valid [ND];
  logic [127:0] drv_data  [ND][8];
  logic         drv_ready [ND];
  logic         drv_clear [ND];

  logic [7:0]   mon_rdy [ND];
  logic         mon_ov  [ND];
  logic [127:0] mon_od  [ND];
  logic [7:0]   mon_src [ND];
  logic [15:0]  mon_cnt [ND];

  // Instance 0: 2 channels, 128-bit, fixed priority, 16-bit counter
  logic [1:0]   a_valid, a_rdy;
  logic [255:0] a_data;
  logic         a_ov, a_src;
  logic [127:0] a_od;
  logic [15:0]  a_cnt;
  assign a_valid = drv_valid[0][1:0];
  assign a_data  = {drv_data[0][1], drv_data[0][0]};

  data_sel_reg #(.DATA_WIDTH(128), .NUM_CH(2), .RR_MODE(0), .CNT_W(16)) u_a (
    .clk(clk), .n_rst(n_rst), .clear(drv_clear[0]), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_rdy), .out_valid(a_ov), .out_data(a_od), .out_src(a_src),
    .out_ready(drv_ready[0]), .acc_count(a_cnt));

  // Instance 1: 4 channels, 32-bit, round-robin, 4-bit counter
  logic [3:0]   b_valid, b_rdy;
  logic [127:0] b_data;
  logic         b_ov;
  logic [1:0]   b_src;
  logic [31:0]  b_od;
  logic [3:0]   b_cnt;
  assign b_valid = drv_valid[1][3:0];
  assign b_data  = {drv_data[1][3][31:0], drv_data[1][2][31:0], drv_data[1][1][31:0], drv_data[1][0][31:0]};

  data_sel_reg #(.DATA_WIDTH(32), .NUM_CH(4), .RR_MODE(1), .CNT_W(4)) u_b (
    .clk(clk), .n_rst(n_rst), .clear(drv_clear[1]), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_rdy), .out_valid(b_ov), .out_data(b_od), .out_src(b_src),
    .out_ready(drv_ready[1]), .acc_count(b_cnt));

  // Instance 2: 3 channels (non power of two), 8-bit, round-robin, 5-bit counter
  logic [2:0]   c_valid, c_rdy;
  logic [23:0]  c_data;
  logic         c_ov;
  logic [1:0]   c_src;
  logic [7:0]   c_od;
  logic [4:0]   c_cnt;
  assign c_valid = drv_valid[2][2:0];
  assign c_data  = {drv_data[2][2][7:0], drv_data[2][1][7:0], drv_data[2][0][7:0]};

  data_sel_reg #(.DATA_WIDTH(8), .NUM_CH(3), .RR_MODE(1), .CNT_W(5)) u_c (
    .clk(clk), .n_rst(n_rst), .clear(drv_clear[2]), .in_valid(c_valid), .in_data(c_data),
    .in_ready(c_rdy), .out_valid(c_ov), .out_data(c_od), .out_src(c_src),
    .out_ready(drv_ready[2]), .acc_count(c_cnt));

  assign mon_rdy[0] = 8'(a_rdy);  assign mon_ov[0] = a_ov;
  assign mon_od[0]  = a_od;       assign mon_src[0] = 8'(a_src);  assign mon_cnt[0] = a_cnt;
  assign mon_rdy[1] = 8'(b_rdy);  assign mon_ov[1] = b_ov;
  assign mon_od[1]  = 128'(b_od); assign mon_src[1] = 8'(b_src);  assign mon_cnt[1] = 16'(b_cnt);
  assign mon_rdy[2] = 8'(c_rdy);  assign mon_ov[2] = c_ov;
  assign mon_od[2]  = 128'(c_od); assign mon_src[2] = 8'(c_src);  assign mon_cnt[2] = 16'(c_cnt);

  function automatic int nch(int d); return (d == 0) ? 2 : ((d == 1) ? 4 : 3); endfunction
  function automatic bit is_rr(int d); return d != 0; endfunction
  function automatic int cw(int d); return (d == 0) ? 16 : ((d == 1) ? 4 : 5); endfunction
  function automatic int dw(int d); return (d == 0) ? 128 : ((d == 1) ? 32 : 8); endfunction
  function automatic logic [127:0] dmask(int d);
    if (dw(d) == 128) return '1;
    return (128'd1 << dw(d)) - 128'd1;
  endfunction

  // Behavioural model state
  bit           m_valid [ND];
  logic [127:0] m_data  [ND];
  int           m_src   [ND];
  int           m_ptr   [ND];
  int           m_cnt   [ND];
  int           g_exp   [ND];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_grant(int d);
    int base, idx;
    if (drv_clear[d]) return -1;
    if (m_valid[d] && !drv_ready[d]) return -1;
    base = is_rr(d) ? m_ptr[d] : 0;
    for (int k = 0; k < nch(d); k++) begin
      idx = (base + k) % nch(d);
      if (drv_valid[d][idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      m_valid[d] = 0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0; g_exp[d] = -1;
    end
  endtask

  task automatic check_regs(input int d);
    chk($sformatf("out_valid[%0d]", d), 128'(mon_ov[d]), 128'(m_valid[d]));
    chk($sformatf("out_data[%0d]", d), mon_od[d], m_data[d]);
    chk($sformatf("out_src[%0d]", d), 128'(mon_src[d]), 128'(m_src[d]));
    chk($sformatf("acc_count[%0d]", d), 128'(mon_cnt[d]), 128'(m_cnt[d]));
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    int g;
    #1;
    for (int d = 0; d < ND; d++) begin
      g_exp[d] = exp_grant(d);
      chk($sformatf("in_ready[%0d]", d), 128'(mon_rdy[d]),
          (g_exp[d] >= 0) ? (128'd1 << g_exp[d]) : 128'd0);
    end
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      g = g_exp[d];
      if (drv_clear[d]) begin
        m_valid[d] = 0; m_data[d] = '0; m_src[d] = 0; m_ptr[d] = 0; m_cnt[d] = 0;
      end else if (g >= 0) begin
        m_valid[d] = 1;
        m_data[d]  = drv_data[d][g] & dmask(d);
        m_src[d]   = g;
        m_cnt[d]   = (m_cnt[d] + 1) % (1 << cw(d));
        if (is_rr(d)) m_ptr[d] = (g + 1) % nch(d);
      end else if (m_valid[d] && drv_ready[d]) begin
        m_valid[d] = 0;
      end
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_regs(d);
  endtask

  task automatic randomize_inputs();
    for (int d = 0; d < ND; d++) begin
      drv_ready[d] = ($urandom_range(0, 9) < 7);
      drv_clear[d] = ($urandom_range(0, 99) < 2);
      for (int c = 0; c < nch(d); c++) begin
        if (drv_valid[d][c] && (g_exp[d] != c)) begin
          // unaccepted word is held stable by its source
        end else if ($urandom_range(0, 9) < 6) begin
          drv_valid[d][c] = 1'b1;
          drv_data[d][c]  = {$urandom, $urandom, $urandom, $urandom} & dmask(d);
        end else begin
          drv_valid[d][c] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      drv_valid[d] = '0; drv_ready[d] = 1'b1; drv_clear[d] = 1'b0;
      for (int c = 0; c < 8; c++) drv_data[d][c] = '0;
    end
    model_reset();
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) check_regs(d);
    chk("reset in_ready", 128'(mon_rdy[0]), 128'd0);
    chk("reset out_valid lit", 128'(mon_ov[0]), 128'd0);
    chk("reset acc_count lit", 128'(mon_cnt[0]), 128'd0);
    @(negedge clk);
    step();

    // Single-channel pass on the 2-channel fixed-priority instance
    drv_valid[0] = 8'b01;
    drv_data[0][0] = {16{8'hA5}};
    step();
    chk("pass out_valid", 128'(mon_ov[0]), 128'd1);
    chk("pass out_data", mon_od[0], {16{8'hA5}});
    chk("pass out_src", 128'(mon_src[0]), 128'd0);
    chk("pass acc_count", 128'(mon_cnt[0]), 128'd1);
    drv_valid[0] = 8'b00;
    step();
    chk("pass drained", 128'(mon_ov[0]), 128'd0);
    chk("pass data held", mon_od[0], {16{8'hA5}});

    // Fixed-priority contention
    drv_data[0][0] = {16{8'h11}};
    drv_data[0][1] = {16{8'h22}};
    drv_valid[0] = 8'b11;
    step();
    chk("prio c1 data", mon_od[0], {16{8'h11}});
    chk("prio c1 cnt", 128'(mon_cnt[0]), 128'd2);
    step();
    chk("prio c2 src", 128'(mon_src[0]), 128'd0);
    chk("prio c2 cnt", 128'(mon_cnt[0]), 128'd3);
    drv_valid[0] = 8'b10;
    step();
    chk("prio ch1 src", 128'(mon_src[0]), 128'd1);
    chk("prio ch1 data", mon_od[0], {16{8'h22}});
    chk("prio ch1 cnt", 128'(mon_cnt[0]), 128'd4);

    // Backpressure while full
    drv_ready[0] = 1'b0;
    drv_data[0][1] = {16{8'h33}};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp out_valid", 128'(mon_ov[0]), 128'd1);
      chk("bp out_data", mon_od[0], {16{8'h22}});
      chk("bp in_ready", 128'(mon_rdy[0]), 128'd0);
    end
    drv_ready[0] = 1'b1;
    step();
    chk("bp release valid", 128'(mon_ov[0]), 128'd1);
    chk("bp release data", mon_od[0], {16{8'h33}});
    chk("bp release cnt", 128'(mon_cnt[0]), 128'd5);
    drv_valid[0] = 8'b00;
    step();

    // Round-robin with all four channels requesting
    for (int c = 0; c < 4; c++) drv_data[1][c] = 128'(32'hB000_0000 + c);
    drv_valid[1] = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr src %0d", i), 128'(mon_src[1]), 128'(i % 4));
      chk($sformatf("rr data %0d", i), mon_od[1], 128'(32'hB000_0000 + (i % 4)));
    end
    chk("rr cnt 8", 128'(mon_cnt[1]), 128'd8);
    for (int i = 0; i < 8; i++) step();
    chk("wrap cnt", 128'(mon_cnt[1]), 128'd0);
    step();
    chk("post-wrap cnt", 128'(mon_cnt[1]), 128'd1);
    chk("post-wrap src", 128'(mon_src[1]), 128'd0);

    // Clear while full with a non-zero pointer
    drv_clear[1] = 1'b1;
    #1;
    chk("clear in_ready", 128'(mon_rdy[1]), 128'd0);
    step();
    chk("clear valid", 128'(mon_ov[1]), 128'd0);
    chk("clear cnt", 128'(mon_cnt[1]), 128'd0);
    chk("clear src", 128'(mon_src[1]), 128'd0);
    chk("clear data", mon_od[1], 128'd0);
    drv_clear[1] = 1'b0;
    step();
    chk("clear ptr src", 128'(mon_src[1]), 128'd0);
    chk("clear ptr cnt", 128'(mon_cnt[1]), 128'd1);
    drv_valid[1] = 8'h00;
    step();

    // Randomised traffic on all instances
    for (int cyc = 0; cyc < 3000; cyc++) begin
      randomize_inputs();
      step();
    end

    // Reset asserted with a transfer pending
    for (int d = 0; d < ND; d++) begin
      drv_clear[d] = 1'b0; drv_ready[d] = 1'b1; drv_valid[d] = 8'hFF;
    end
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < ND; d++) check_regs(d);
    @(negedge clk);
    for (int d = 0; d < ND; d++) check_regs(d);
    for (int d = 0; d < ND; d++) drv_valid[d] = 8'h00;
    n_rst = 1'b1;
    step();
    drv_valid[2] = 8'b111;
    drv_data[2][0] = 128'h5A;
    step();
    chk("post-reset rr src", 128'(mon_src[2]), 128'd0);
    chk("post-reset rr data", mon_od[2], 128'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
